// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the CPU pipeline control blocks.
//   RW          register index width (16 registers, r0 reads as zero)
//   OP_*/XOP_*  primary opcode and extended-op encodings of the ISA
//   sb_entry_t  one scoreboard slot: {valid, destination register, late result}
//   ctl_state_t run/halt state of the pipeline controller
//   reg_onehot  one-hot decode of a register index
package cpu_pkg;

  localparam int RW = 4;

  // Primary opcodes
  localparam logic [3:0] OP_SUB  = 4'h0;
  localparam logic [3:0] OP_MOVL = 4'h8;
  localparam logic [3:0] OP_MOVH = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'he;
  localparam logic [3:0] OP_MEM  = 4'hf;

  // Extended ops carried in the jump / memory forms
  localparam logic [3:0] XOP_JZ  = 4'h0;
  localparam logic [3:0] XOP_JNZ = 4'h1;
  localparam logic [3:0] XOP_JS  = 4'h2;
  localparam logic [3:0] XOP_JNS = 4'h3;
  localparam logic [3:0] XOP_LD  = 4'h0;
  localparam logic [3:0] XOP_ST  = 4'h1;

  typedef struct packed {
    logic          v;
    logic [RW-1:0] wreg;
    logic          late;
  } sb_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } ctl_state_t;

  function automatic logic [2**RW-1:0] reg_onehot(input logic [RW-1:0] r);
    reg_onehot    = '0;
    reg_onehot[r] = 1'b1;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: shift register of in-flight register writes, one slot per
// stage from execute0 (slot 0) to writeback (slot DEPTH-1).
//   clk, rst_n          clock, asynchronous active-low reset
//   advance_i           shift this edge (low freezes the whole scoreboard)
//   clear_i             flush edge: everything younger than writeback is dropped
//   load_v_i/_wreg_i/_late_i  entry entering execute0 this edge
//   ra_i/rb_i/rt_i, use_*_i   decode source registers and their use flags
//   hazard_o            a used source waits on a late producer not yet at writeback
//   busy_mask_o         registered OR of one-hot destinations of valid slots
module pipe_scoreboard
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance_i,
  input  logic              clear_i,
  input  logic              load_v_i,
  input  logic [RW-1:0]     load_wreg_i,
  input  logic              load_late_i,
  input  logic [RW-1:0]     ra_i,
  input  logic [RW-1:0]     rb_i,
  input  logic [RW-1:0]     rt_i,
  input  logic              use_ra_i,
  input  logic              use_rb_i,
  input  logic              use_rt_i,
  output logic              hazard_o,
  output logic [2**RW-1:0]  busy_mask_o
);

  sb_entry_t          sb_q [DEPTH];
  sb_entry_t          sb_d [DEPTH];
  logic [2**RW-1:0]   busy_q;
  logic [2**RW-1:0]   busy_d;
  logic [DEPTH-2:0]   hit;

  // On a flush edge the writeback slot retires as usual while every younger
  // slot is squashed, and nothing issues into execute0, so the whole
  // scoreboard ends up empty.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      sb_d[i] = sb_q[i];
    end
    if (advance_i) begin
      if (clear_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          sb_d[i] = '0;
        end
      end else begin
        sb_d[0].v    = load_v_i;
        sb_d[0].wreg = load_wreg_i;
        sb_d[0].late = load_late_i;
        for (int i = 1; i < DEPTH; i++) begin
          sb_d[i] = sb_q[i-1];
        end
      end
    end
  end

  // busy_mask follows the post-edge scoreboard, so it lines up with sb_q.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_d[i].v) begin
        busy_d = busy_d | reg_onehot(sb_d[i].wreg);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_q[i] <= sb_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Only late producers short of writeback stall; everything else is
  // reachable through the forwarding network. r0 never creates a dependency.
  for (genvar gi = 0; gi < DEPTH - 1; gi++) begin : g_hit
    logic match_a, match_b, match_t;
    assign match_a = use_ra_i && (ra_i != '0) && (ra_i == sb_q[gi].wreg);
    assign match_b = use_rb_i && (rb_i != '0) && (rb_i == sb_q[gi].wreg);
    assign match_t = use_rt_i && (rt_i != '0) && (rt_i == sb_q[gi].wreg);
    assign hit[gi] = sb_q[gi].v && sb_q[gi].late && (match_a || match_b || match_t);
  end

  assign hazard_o    = |hit;
  assign busy_mask_o = busy_q;

endmodule

// File: rtl/pipe_ctl.sv
// pipe_ctl: hazard and flow controller for the five-stage pipeline.
//   clk, rst_n                clock, asynchronous active-low reset
//   dec_*                     instruction currently in decode
//   wb_valid/redirect/illegal writeback-stage status
//   stall   hold fetch0/decode, bubble into execute0
//   flush   invalidate fetch0..execute2 (writeback redirect)
//   issue   decode instruction advances into execute0 this cycle
//   halted  sticky, set the cycle after an illegal op reaches writeback
//   busy_mask registers with a write still in flight
module pipe_ctl #(
  parameter int DEPTH  = 4,
  parameter int REFILL = 2,
  parameter int RW     = cpu_pkg::RW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  input  logic [RW-1:0]     dec_ra,
  input  logic [RW-1:0]     dec_rb,
  input  logic [RW-1:0]     dec_rt,
  input  logic              dec_use_ra,
  input  logic              dec_use_rb,
  input  logic              dec_use_rt,
  input  logic              dec_wen,
  input  logic [RW-1:0]     dec_wreg,
  input  logic              dec_late,
  input  logic              wb_valid,
  input  logic              wb_redirect,
  input  logic              wb_illegal,
  output logic              stall,
  output logic              flush,
  output logic              issue,
  output logic              halted,
  output logic [2**RW-1:0]  busy_mask
);

  import cpu_pkg::*;

  localparam int SHW = (REFILL > 0) ? $clog2(REFILL + 1) : 1;

  ctl_state_t     state_q, state_d;
  logic [SHW-1:0] shadow_q, shadow_d;

  logic running;
  logic illegal_now;
  logic dec_eff;
  logic sb_hazard;
  logic hazard;
  logic load_v;

  assign running     = (state_q == ST_RUN);
  assign illegal_now = running && wb_valid && wb_illegal;
  // Decode is ignored while fetch refills after a flush.
  assign dec_eff     = dec_valid && (shadow_q == '0);
  assign hazard      = dec_eff && sb_hazard;
  assign load_v      = issue && dec_wen && (dec_wreg != '0);

  // The combinational outputs are also gated by rst_n so that every output
  // reads 0 while reset is held, whatever the inputs are doing.
  // Halt outranks everything: the cycle the illegal op sits at writeback
  // already holds decode, and a same-cycle redirect is not honoured.
  always_comb begin
    flush = rst_n && running && wb_valid && wb_redirect && !wb_illegal;
    stall = rst_n && (!running || illegal_now || (hazard && !flush));
    issue = rst_n && running && !illegal_now && dec_eff && !hazard && !flush;
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    if (running) begin
      if (illegal_now) begin
        state_d = ST_HALT;
      end
      if (flush) begin
        shadow_d = SHW'(REFILL);
      end else if (shadow_q != '0) begin
        shadow_d = shadow_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
    end
  end

  assign halted = (state_q == ST_HALT);

  pipe_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance_i   (running),
    .clear_i     (flush),
    .load_v_i    (load_v),
    .load_wreg_i (dec_wreg),
    .load_late_i (dec_late),
    .ra_i        (dec_ra),
    .rb_i        (dec_rb),
    .rt_i        (dec_rt),
    .use_ra_i    (dec_use_ra),
    .use_rb_i    (dec_use_rb),
    .use_rt_i    (dec_use_rt),
    .hazard_o    (sb_hazard),
    .busy_mask_o (busy_mask)
  );

endmodule

// File: tb/tb_pipe_ctl.sv
// tb_pipe_ctl: scoreboard-checked bench for pipe_ctl. A driver applies one
// decode/writeback pattern per cycle and pushes the response predicted by a
// reference model (list of in-flight producers tagged with issue time); a
// monitor pops and compares on the falling edge.
module tb_pipe_ctl;

  localparam int DEPTH  = 4;
  localparam int REFILL = 2;
  localparam int RW     = 4;
  localparam int NREG   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            dec_valid = 1'b0;
  logic [RW-1:0]   dec_ra = '0, dec_rb = '0, dec_rt = '0;
  logic            dec_use_ra = 1'b0, dec_use_rb = 1'b0, dec_use_rt = 1'b0;
  logic            dec_wen = 1'b0;
  logic [RW-1:0]   dec_wreg = '0;
  logic            dec_late = 1'b0;
  logic            wb_valid = 1'b0, wb_redirect = 1'b0, wb_illegal = 1'b0;
  logic            stall, flush, issue, halted;
  logic [NREG-1:0] busy_mask;

  always #5 clk = ~clk;

  pipe_ctl #(
    .DEPTH  (DEPTH),
    .REFILL (REFILL),
    .RW     (RW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_valid   (dec_valid),
    .dec_ra      (dec_ra),
    .dec_rb      (dec_rb),
    .dec_rt      (dec_rt),
    .dec_use_ra  (dec_use_ra),
    .dec_use_rb  (dec_use_rb),
    .dec_use_rt  (dec_use_rt),
    .dec_wen     (dec_wen),
    .dec_wreg    (dec_wreg),
    .dec_late    (dec_late),
    .wb_valid    (wb_valid),
    .wb_redirect (wb_redirect),
    .wb_illegal  (wb_illegal),
    .stall       (stall),
    .flush       (flush),
    .issue       (issue),
    .halted      (halted),
    .busy_mask   (busy_mask)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int wreg;
    bit late;
    int birth;   // model time at which the producer sits in execute0
  } prod_t;

  typedef struct {
    bit              stall;
    bit              flush;
    bit              issue;
    bit              halted;
    logic [NREG-1:0] busy;
    string           tag;
  } exp_t;

  prod_t prods[$];
  exp_t  expq[$];
  int    m_time;     // advances only while the pipeline runs
  int    m_shadow;
  bit    m_halted;
  int    checks = 0;
  int    errors = 0;

  task automatic model_reset();
    prods.delete();
    m_time   = 0;
    m_shadow = 0;
    m_halted = 0;
  endtask

  function automatic logic [NREG-1:0] model_busy();
    logic [NREG-1:0] m;
    m = '0;
    foreach (prods[i]) m[prods[i].wreg] = 1'b1;
    return m;
  endfunction

  // One cycle: drive inputs, predict outputs, advance the model, wait an edge.
  task automatic step(input bit dv, input int ra, input int rb, input int rt,
                      input bit ura, input bit urb, input bit urt,
                      input bit wen, input int wreg, input bit late,
                      input bit wbv, input bit redir, input bit ill,
                      input string tag);
    exp_t e;
    bit   dve, haz, ill_now, fl;
    int   age;
    dec_valid = dv;  dec_ra = RW'(ra); dec_rb = RW'(rb); dec_rt = RW'(rt);
    dec_use_ra = ura; dec_use_rb = urb; dec_use_rt = urt;
    dec_wen = wen; dec_wreg = RW'(wreg); dec_late = late;
    wb_valid = wbv; wb_redirect = redir; wb_illegal = ill;

    dve = dv && (m_shadow == 0);
    haz = 0;
    foreach (prods[i]) begin
      age = m_time - prods[i].birth;
      // a late result becomes forwardable only once it reaches writeback
      if (prods[i].late && age < DEPTH - 1 &&
          ((ura && ra != 0 && ra == prods[i].wreg) ||
           (urb && rb != 0 && rb == prods[i].wreg) ||
           (urt && rt != 0 && rt == prods[i].wreg)))
        haz = 1;
    end
    haz     = haz && dve;
    ill_now = !m_halted && wbv && ill;
    fl      = !m_halted && wbv && redir && !ill;

    e.stall  = m_halted || ill_now || (haz && !fl);
    e.flush  = fl;
    e.issue  = !m_halted && !ill_now && dve && !haz && !fl;
    e.halted = m_halted;
    e.busy   = model_busy();
    e.tag    = tag;
    expq.push_back(e);

    if (!m_halted) begin
      m_time++;
      if (fl) begin
        prods.delete();
        m_shadow = REFILL;
      end else if (m_shadow > 0) begin
        m_shadow--;
      end
      if (e.issue && wen && wreg != 0)
        prods.push_back('{wreg: wreg, late: late, birth: m_time});
      for (int i = prods.size() - 1; i >= 0; i--)
        if (m_time - prods[i].birth > DEPTH - 1) prods.delete(i);
      if (ill_now) m_halted = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_zero(input string tag);
    exp_t e;
    e.stall = 0; e.flush = 0; e.issue = 0; e.halted = 0; e.busy = '0; e.tag = tag;
    expq.push_back(e);
  endtask

  // Asserted mid-cycle with busy inputs so the async clear is observed before
  // any clock edge; released mid-cycle as well.
  task automatic do_reset(input int cycles, input string tag);
    rst_n = 1'b0;
    dec_valid = 1'b1; wb_valid = 1'b1; wb_redirect = 1'b1; wb_illegal = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      push_zero(tag);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic rnd(input int n, input int redir_div, input int ill_div, input string tag);
    bit wen;
    for (int i = 0; i < n; i++) begin
      wen = ($urandom_range(0, 1) == 1);
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           wen, (wen ? $urandom_range(0, 15) : 0), wen && ($urandom_range(0, 2) == 0),
           $urandom_range(0, 1) == 1,
           (redir_div > 0) && ($urandom_range(1, redir_div) == 1),
           (ill_div > 0) && ($urandom_range(1, ill_div) == 1),
           tag);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      $display("%0t %s: stall=%0b flush=%0b issue=%0b halted=%0b busy=%04h",
               $time, e.tag, stall, flush, issue, halted, busy_mask);
      chk({e.tag, " stall"},  32'(stall),     32'(e.stall));
      chk({e.tag, " flush"},  32'(flush),     32'(e.flush));
      chk({e.tag, " issue"},  32'(issue),     32'(e.issue));
      chk({e.tag, " halted"}, 32'(halted),    32'(e.halted));
      chk({e.tag, " busy"},   32'(busy_mask), 32'(e.busy));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2, "reset");

    // load-use: ld r3 then sub r4 = r3 - r2 presented until it issues
    step(1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, "ld_r3");
    for (int i = 0; i < 4; i++)
      step(1, 3, 2, 0, 1, 1, 0, 1, 4, 0, 0, 0, 0, "sub_r4_r3");
    idle(2, "idle");

    // ALU producer is forwarded; r0 never becomes busy
    step(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, "movl_r5");
    step(1, 5, 5, 5, 1, 1, 1, 1, 6, 0, 0, 0, 0, "read_r5");
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, "ld_r0");
    step(1, 0, 0, 0, 1, 1, 1, 1, 7, 0, 0, 0, 0, "read_r0");
    idle(4, "idle");

    // redirect: flush, refill shadow, then issue resumes
    step(1, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, "ld_r7");
    step(1, 1, 2, 0, 1, 1, 0, 1, 8, 0, 0, 0, 0, "sub_r8");
    step(1, 1, 2, 0, 1, 1, 0, 1, 9, 0, 1, 1, 0, "redirect");
    for (int i = 0; i < 3; i++)
      step(1, 1, 2, 0, 1, 1, 0, 1, 10, 0, 0, 0, 0, "refill");
    idle(3, "idle");

    // pending load hazard coincides with a redirect
    step(1, 0, 0, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, "ld_r6");
    step(1, 6, 0, 0, 1, 0, 0, 1, 11, 0, 1, 1, 0, "haz_and_flush");
    idle(3, "idle");

    // reset in the middle of a load-use stall
    step(1, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0, "ld_r9");
    step(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "use_r9");
    do_reset(1, "reset_mid_stall");
    step(1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "after_reset");

    // reset in the middle of the refill shadow
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "redirect2");
    do_reset(1, "reset_mid_shadow");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "after_reset2");

    // random traffic with redirects
    rnd(300, 12, 0, "rand");
    do_reset(2, "reset");
    rnd(300, 6, 0, "rand_flushy");

    // illegal + redirect together: halt wins, then sticky until reset
    step(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 1, 1, "illegal");
    rnd(6, 4, 0, "halted_rand");
    do_reset(2, "reset_from_halt");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "after_halt_reset");

    // random traffic where an illegal op can end the run early
    rnd(250, 10, 120, "rand_ill");
    do_reset(1, "final_reset");
    idle(2, "idle");

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses left, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
